stack_alu_sequencer: RTL
========================

Name: stack_alu_sequencer

Overview:
- Master-side issuer for the stack-based ALU.
- Accepts a postfix (RPN) token stream from a host over a valid/ready handshake and drives the ALU's opcode/data inputs one instruction at a time.
- Tracks stack depth, samples the ALU's overflow flag, pops the final value, and returns the result with status over a second valid/ready handshake.
- On malformed expressions it drains the ALU stack so the next expression starts clean.

Parameters:
DATA_WIDTH, 16, operand/result width; matches ALU DATA_WIDTH
STACK_SIZE, 64, ALU stack depth; sequencer depth-limit check
DEPTH_W, 7, depth counter width; must hold 0..STACK_SIZE

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tok_valid  input  1  host token valid
tok_ready  output  1  sequencer can accept token
tok_is_op  input  1  1 = operator token, 0 = operand token
tok_data  input  DATA_WIDTH  operand value; for operators bit0: 0=add, 1=multiply
tok_last  input  1  final token of expression
alu_opcode  output  3  to ALU opcode
alu_data  output  DATA_WIDTH  to ALU input_data
alu_result  input  DATA_WIDTH  from ALU output_data
alu_overflow  input  1  from ALU overflow
res_valid  output  1  result available
res_ready  input  1  host accepts result
res_data  output  DATA_WIDTH  popped result (0 on error)
res_ovf  output  1  sticky: any arithmetic op in the expression overflowed
res_err  output  2  00 ok, 01 underflow, 10 stack full, 11 malformed

Behaviour:
- ALU opcode encoding:
  - 3'b100 add, 3'b101 multiply, 3'b110 push, 3'b111 pop, 3'b000 no-op.
  - The ALU acts on the rising edge where the opcode is presented; output_data/overflow are valid after that edge.
- Reset (async, rst_n=0), all registered:
  - state=ACCEPT, depth=0, alu_opcode=000, alu_data=0.
  - res_valid=0, res_data=0, res_ovf=0, res_err=00.
  - tok_ready=0 while rst_n=0, 1 from the first cycle after release.
  - Reset mid-expression leaves stale entries in the ALU; depth tracking restarts at 0.
- alu_opcode/alu_data are registered. A non-NOP opcode is held for exactly one cycle, then 000.
- tok_ready=1 only in ACCEPT and DISCARD.
- States:
  - ACCEPT:
    - Operand handshake:
      - If depth==STACK_SIZE: err=10.
      - Else push (alu_opcode<=110, alu_data<=tok_data), depth++.
      - Back-to-back pushes allowed, one per cycle.
    - Operator handshake:
      - If depth<2: err=01.
      - Else alu_opcode<=100|tok_data[0], depth--, go OP_EXEC.
    - First token of an expression clears res_ovf.
    - tok_last with no error:
      - Operand: go POP after the push.
      - Operator: go POP after OP_SAMPLE.
      - Final depth != 1: err=11.
      - Final depth == 0: err=01.
    - Any error: latch err; if !tok_last go DISCARD, else go FLUSH.
  - OP_EXEC: one cycle; ALU executes at the end edge.
  - OP_SAMPLE: one cycle; res_ovf <= res_ovf | alu_overflow; go ACCEPT, or POP if last.
  - POP: alu_opcode=111, depth--; go CAPTURE.
  - CAPTURE: at end edge res_data<=alu_result, res_err=00; go RESULT.
  - DISCARD: consume tokens without issuing; on tok_last handshake go FLUSH.
  - FLUSH:
    - Issue POP each cycle while depth>0 (depth--).
    - At depth==0: res_data<=0, go RESULT.
  - RESULT: res_valid=1; outputs stable until res_ready; on handshake res_valid<=0, go ACCEPT.
- Simultaneous events:
  - An error takes priority over tok_last completion.
  - Stack full is checked before underflow (they are exclusive by token type).
- Latency:
  - Operand-only expression: last-token handshake to res_valid = 3 cycles (push, POP, CAPTURE).
  - Operator last token: 4 cycles (OP_EXEC, OP_SAMPLE, POP, CAPTURE).
- Depth arithmetic is unsigned; never wraps because of the full/underflow checks.

Test Plan:
- Tokens 0x0003, 0x0002, op(mul, last):
  - ALU opcode sequence 110, 110, 101, 000, 111.
  - res_data=0x0006, res_ovf=0, res_err=00.
- Tokens 0x0100, 0x0100, op(mul, last):
  - res_ovf=1, res_data = ALU truncated result 0x0000, res_err=00.
  - Next expression 0x0001(last) returns res_ovf=0.
- op(add) as first token, then 0x0005(last):
  - Underflow: no ALU op issued for the operator; 0x0005 discarded with no push.
  - res_err=01, res_data=0, zero POPs.
- Tokens 0x0001, 0x0002(last):
  - res_err=11.
  - Push, push, then exactly two POP opcodes in FLUSH; depth ends 0.
- STACK_SIZE=4: five operands, the fifth with last:
  - res_err=10; four POPs issued in FLUSH.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid:
  - res_data/res_err stable, tok_ready=0.
  - Assert res_ready, then the next token is accepted on the following cycle.

Source files
------------

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: issues an RPN token stream to a stack ALU one opcode at a
// time, tracks stack depth, collects the overflow flag, pops the final value and
// returns it with a status code. Malformed expressions drain the ALU stack.
module stack_alu_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int STACK_SIZE = 64,
    parameter int DEPTH_W    = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic                  tok_is_op,
    input  logic [DATA_WIDTH-1:0] tok_data,
    input  logic                  tok_last,
    output logic [2:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_ovf,
    output logic [1:0]            res_err
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_FULL  = 2'b10;
    localparam logic [1:0] ERR_MALF  = 2'b11;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_SIZE);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

    // S_PUSH_LAST is the cycle in which the final push is on the ALU bus;
    // S_POP is the cycle in which the final pop is on the ALU bus.
    typedef enum logic [3:0] {
        S_ACCEPT,
        S_PUSH_LAST,
        S_OP_EXEC,
        S_OP_SAMPLE,
        S_POP,
        S_CAPTURE,
        S_DISCARD,
        S_FLUSH,
        S_RESULT
    } state_t;

    state_t                r_state;
    logic                  r_ready_en;   // low until the first edge after reset release
    logic                  r_first;      // next accepted token starts a new expression
    logic                  r_last;       // pending operator was the final token
    logic [DEPTH_W-1:0]    r_depth;
    logic [2:0]            r_opcode;
    logic [DATA_WIDTH-1:0] r_alu_data;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_ovf;
    logic [1:0]            r_err;

    logic w_tok_hs;
    logic w_full;
    logic w_under;

    assign tok_ready  = r_ready_en && (r_state == S_ACCEPT || r_state == S_DISCARD);
    assign w_tok_hs   = tok_valid && tok_ready;
    assign w_full     = (r_depth == DEPTH_FULL);
    assign w_under    = (r_depth < DEPTH_TWO);

    assign alu_opcode = r_opcode;
    assign alu_data   = r_alu_data;
    assign res_valid  = r_valid;
    assign res_data   = r_res_data;
    assign res_ovf    = r_ovf;
    assign res_err    = r_err;

    // Sequencer FSM: token intake, ALU issue, depth tracking and result return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_ACCEPT;
            r_ready_en <= 1'b0;
            r_first    <= 1'b1;
            r_last     <= 1'b0;
            r_depth    <= '0;
            r_opcode   <= OP_NOP;
            r_alu_data <= '0;
            r_valid    <= 1'b0;
            r_res_data <= '0;
            r_ovf      <= 1'b0;
            r_err      <= ERR_OK;
        end else begin
            r_ready_en <= 1'b1;
            r_opcode   <= OP_NOP;      // any issued opcode lasts one cycle
            case (r_state)
                S_ACCEPT: begin
                    if (w_tok_hs) begin
                        r_first <= 1'b0;
                        if (r_first) r_ovf <= 1'b0;
                        if (!tok_is_op) begin
                            if (w_full) begin
                                r_err   <= ERR_FULL;
                                r_state <= tok_last ? S_FLUSH : S_DISCARD;
                            end else begin
                                r_opcode   <= OP_PUSH;
                                r_alu_data <= tok_data;
                                r_depth    <= r_depth + 1'b1;
                                if (tok_last) begin
                                    // final depth is r_depth+1; anything but 1 is malformed
                                    if (r_depth != '0) begin
                                        r_err   <= ERR_MALF;
                                        r_state <= S_FLUSH;
                                    end else begin
                                        r_state <= S_PUSH_LAST;
                                    end
                                end
                            end
                        end else begin
                            if (w_under) begin
                                r_err   <= ERR_UNDER;
                                r_state <= tok_last ? S_FLUSH : S_DISCARD;
                            end else begin
                                r_opcode <= {2'b10, tok_data[0]};
                                r_depth  <= r_depth - 1'b1;
                                r_last   <= tok_last;
                                r_state  <= S_OP_EXEC;
                            end
                        end
                    end
                end
                S_PUSH_LAST: begin
                    r_opcode <= OP_POP;
                    r_depth  <= r_depth - 1'b1;
                    r_state  <= S_POP;
                end
                S_OP_EXEC: begin
                    r_state <= S_OP_SAMPLE;
                end
                S_OP_SAMPLE: begin
                    r_ovf <= r_ovf | alu_overflow;
                    if (!r_last) begin
                        r_state <= S_ACCEPT;
                    end else if (r_depth == DEPTH_ONE) begin
                        r_opcode <= OP_POP;
                        r_depth  <= r_depth - 1'b1;
                        r_state  <= S_POP;
                    end else begin
                        r_err   <= (r_depth == '0) ? ERR_UNDER : ERR_MALF;
                        r_state <= S_FLUSH;
                    end
                end
                S_POP: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_res_data <= alu_result;
                    r_err      <= ERR_OK;
                    r_valid    <= 1'b1;
                    r_state    <= S_RESULT;
                end
                S_DISCARD: begin
                    if (w_tok_hs && tok_last) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_depth != '0) begin
                        r_opcode <= OP_POP;
                        r_depth  <= r_depth - 1'b1;
                    end else begin
                        r_res_data <= '0;
                        r_valid    <= 1'b1;
                        r_state    <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_first <= 1'b1;
                        r_state <= S_ACCEPT;
                    end
                end
                default: begin
                    r_state <= S_ACCEPT;
                end
            endcase
        end
    end

endmodule
